sensor_scanner: RTL and testbench

Acquisition front end for the temperature monitor. It polls each temperature sensor in turn over a per-sensor request/acknowledge handshake and collects the 8-bit readings. It then publishes them atomically as the packed `sensors_data_o` / `sensors_en_o` bus that the averaging/display datapath consumes. Sensors that fail to answer within a timeout are reported as disabled, so they are excluded from the average.

---
 rtl/sensor_scanner.sv | 112 +++++++++++
 tb/tb_sensor_scanner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_scanner.sv
// Temperature sensor acquisition front end: polls each sensor over a req/ack
// handshake with a per-sensor timeout and publishes the whole set atomically.
module sensor_scanner #(
    parameter int NUM_SENSORS = 5,
    parameter int TIMEOUT     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     scan_en_i,
    output logic [NUM_SENSORS-1:0]   sensor_req_o,
    input  logic [NUM_SENSORS-1:0]   sensor_ack_i,
    input  logic [7:0]               sensor_value_i,
    output logic [8*NUM_SENSORS-1:0] sensors_data_o,
    output logic [NUM_SENSORS-1:0]   sensors_en_o,
    output logic                     update_o,
    output logic                     busy_o
);

    localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SENSORS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, NEXT, PUBLISH} state_t;

    state_t                        state_q;
    logic [IDX_W-1:0]              idx_q;
    logic [TMR_W-1:0]              tmr_q;
    logic [NUM_SENSORS-1:0][7:0]   shadow_data_q;
    logic [NUM_SENSORS-1:0]        shadow_en_q;
    logic [NUM_SENSORS-1:0]        req_q;
    logic [8*NUM_SENSORS-1:0]      data_q;
    logic [NUM_SENSORS-1:0]        en_q;
    logic                          update_q;
    logic                          busy_q;

    logic [IDX_W-1:0]              idx_d;

    assign idx_d = idx_q + IDX_W'(1);

    function automatic logic [NUM_SENSORS-1:0] one_hot(input logic [IDX_W-1:0] i);
        one_hot = NUM_SENSORS'(1) << i;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            tmr_q         <= '0;
            shadow_data_q <= '0;
            shadow_en_q   <= '0;
            req_q         <= '0;
            data_q        <= '0;
            en_q          <= '0;
            update_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (scan_en_i) begin
                        idx_q   <= '0;
                        tmr_q   <= '0;
                        req_q   <= one_hot('0);
                        busy_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    tmr_q <= tmr_q + TMR_W'(1);
                    // Ack is checked first so a reply on the final wait cycle still counts.
                    if (sensor_ack_i[idx_q]) begin
                        shadow_data_q[idx_q] <= sensor_value_i;
                        shadow_en_q[idx_q]   <= 1'b1;
                        req_q                <= '0;
                        state_q              <= NEXT;
                    end else if (tmr_q == TMR_LAST) begin
                        shadow_data_q[idx_q] <= 8'h00;
                        shadow_en_q[idx_q]   <= 1'b0;
                        req_q                <= '0;
                        state_q              <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        data_q   <= shadow_data_q;
                        en_q     <= shadow_en_q;
                        update_q <= 1'b1;
                        state_q  <= PUBLISH;
                    end else begin
                        idx_q   <= idx_d;
                        tmr_q   <= '0;
                        req_q   <= one_hot(idx_d);
                        state_q <= REQ;
                    end
                end
                PUBLISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sensor_req_o   = req_q;
    assign sensors_data_o = data_q;
    assign sensors_en_o   = en_q;
    assign update_o       = update_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_sensor_scanner.sv
// Directed bench for sensor_scanner: a sensor responder model drives acks and a
// scoreboard queue holds the published set expected for each round.
module tb_sensor_scanner;

    localparam int N = 5;
    localparam int T = 16;

    typedef struct packed {
        logic [8*N-1:0] data;
        logic [N-1:0]   en;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             scan_en_i;
    logic [N-1:0]     sensor_req_o;
    logic [N-1:0]     sensor_ack_i;
    logic [7:0]       sensor_value_i;
    logic [8*N-1:0]   sensors_data_o;
    logic [N-1:0]     sensors_en_o;
    logic             update_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    int         delay   [N];
    logic [7:0] vals    [N];
    bit         stray   [N];
    int         req_len [N];
    exp_t       sb_q[$];
    exp_t       last_pub;
    int         upd_cnt = 0;

    sensor_scanner #(.NUM_SENSORS(N), .TIMEOUT(T)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .scan_en_i      (scan_en_i),
        .sensor_req_o   (sensor_req_o),
        .sensor_ack_i   (sensor_ack_i),
        .sensor_value_i (sensor_value_i),
        .sensors_data_o (sensors_data_o),
        .sensors_en_o   (sensors_en_o),
        .update_o       (update_o),
        .busy_o         (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit answers(input int k);
        return !stray[k] && delay[k] >= 0 && delay[k] < T;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e = '0;
        for (int k = 0; k < N; k++) begin
            if (answers(k)) begin
                e.data[8*k +: 8] = vals[k];
                e.en[k]          = 1'b1;
            end
        end
        return e;
    endfunction

    // Cycles from the IDLE sampling cycle to the PUBLISH cycle
    function automatic int model_latency();
        int n = 1;
        for (int k = 0; k < N; k++) n += (answers(k) ? delay[k] + 1 : T) + 1;
        return n;
    endfunction

    // Sensor model: answers on the configured REQ cycle, records request lengths
    initial begin
        logic [N-1:0] cur, prev;
        int cnt;
        prev = '0; cnt = 0;
        sensor_ack_i = '0; sensor_value_i = 8'h00;
        forever begin
            @(negedge clk_i);
            cur = sensor_req_o;
            if (cur != '0) begin
                chk("req_onehot", 64'($onehot(cur)), 64'd1);
                cnt = (cur == prev) ? cnt + 1 : 1;
                if (stray[oh_idx(cur)]) begin
                    sensor_ack_i   = ~cur;
                    sensor_value_i = 8'hAA;
                end else if (delay[oh_idx(cur)] == cnt - 1) begin
                    sensor_ack_i   = cur;
                    sensor_value_i = vals[oh_idx(cur)];
                end else begin
                    sensor_ack_i   = '0;
                    sensor_value_i = 8'h55;
                end
            end else begin
                if (prev != '0) req_len[oh_idx(prev)] = cnt;
                cnt = 0;
                sensor_ack_i = '0;
            end
            prev = cur;
        end
    end

    // Scoreboard: every update pulse pops one expected published set
    initial begin
        logic prev_upd;
        prev_upd = 1'b0;
        last_pub = '0;
        forever begin
            @(negedge clk_i);
            if (update_o) begin
                upd_cnt++;
                chk("update_single_cycle", 64'(prev_upd), 64'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_update", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("pub_data", 64'(sensors_data_o), 64'(e.data));
                    chk("pub_en", 64'(sensors_en_o), 64'(e.en));
                end
                last_pub = {sensors_data_o, sensors_en_o};
            end
            prev_upd = update_o;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},  64'(sensor_req_o),   64'd0);
        chk({tag, "_data"}, 64'(sensors_data_o), 64'd0);
        chk({tag, "_en"},   64'(sensors_en_o),   64'd0);
        chk({tag, "_upd"},  64'(update_o),       64'd0);
        chk({tag, "_busy"}, 64'(busy_o),         64'd0);
    endtask

    task automatic wait_update(input int maxc, inout int n);
        int c = 0;
        do begin
            @(posedge clk_i); @(negedge clk_i);
            n++; c++;
        end while (!update_o && c < maxc);
        chk("update_seen", 64'(update_o), 64'd1);
    endtask

    task automatic wait_req(input int k, input int maxc);
        int c = 0;
        while (!sensor_req_o[k] && c < maxc) begin
            @(negedge clk_i);
            c++;
        end
        chk("req_seen", 64'(sensor_req_o[k]), 64'd1);
    endtask

    task automatic go_idle(input string tag);
        repeat (3) @(negedge clk_i);
        chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_idle_req"},  64'(sensor_req_o), 64'd0);
    endtask

    // One round started by a short scan_en pulse; checks latency and restart at sensor 0
    task automatic run_round(input string tag);
        int n = 0;
        @(negedge clk_i);
        scan_en_i = 1'b1;
        sb_q.push_back(model());
        @(posedge clk_i); @(negedge clk_i);
        n = 1;
        chk({tag, "_first_req"}, 64'(sensor_req_o), 64'd1);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        scan_en_i = 1'b0;
        wait_update(400, n);
        chk({tag, "_latency"}, 64'(n), 64'(model_latency()));
        go_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, u0;
        rst_i = 1'b1;
        scan_en_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            delay[k] = 0; vals[k] = 8'(20 + k); stray[k] = 1'b0; req_len[k] = 0;
        end
        repeat (3) @(negedge clk_i);
        chk_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_reset_busy", 64'(busy_o), 64'd0);

        // Fast round with scan_en held: publish in cycle 11, next REQ in cycle 13
        scan_en_i = 1'b1;
        sb_q.push_back(model());
        n = 0;
        wait_update(100, n);
        chk("fast_latency", 64'(n), 64'd11);
        chk("fast_data_const", 64'(sensors_data_o), 64'h18_17_16_15_14);
        chk("fast_en_const", 64'(sensors_en_o), 64'h1f);
        sb_q.push_back(model());
        @(posedge clk_i); @(negedge clk_i);
        chk("cycle12_busy", 64'(busy_o), 64'd0);
        chk("cycle12_req", 64'(sensor_req_o), 64'd0);
        @(posedge clk_i); @(negedge clk_i);
        chk("cycle13_req", 64'(sensor_req_o), 64'd1);
        scan_en_i = 1'b0;
        n = 0;
        wait_update(100, n);
        go_idle("fast2");

        // Slowest round: every sensor times out
        for (int k = 0; k < N; k++) delay[k] = -1;
        run_round("slow");
        chk("slow_len4", 64'(req_len[4]), 64'(T));

        // Sensor 2 silent
        for (int k = 0; k < N; k++) begin delay[k] = 0; vals[k] = 8'(20 + k); end
        delay[2] = -1;
        run_round("silent2");
        chk("silent2_len", 64'(req_len[2]), 64'(T));
        chk("silent2_len0", 64'(req_len[0]), 64'd1);

        // Ack on the last permitted REQ cycle
        delay[2] = 0;
        delay[1] = T - 1; vals[1] = 8'd30;
        run_round("acklast");
        chk("acklast_len", 64'(req_len[1]), 64'(T));
        chk("acklast_byte1", 64'(sensors_data_o[15:8]), 64'h1e);
        chk("acklast_en1", 64'(sensors_en_o[1]), 64'd1);

        // Drop scan_en during sensor 3: round completes, outputs hold until publish
        for (int k = 0; k < N; k++) begin delay[k] = k; vals[k] = 8'(50 + k); end
        u0 = upd_cnt;
        @(negedge clk_i);
        scan_en_i = 1'b1;
        sb_q.push_back(model());
        wait_req(3, 200);
        scan_en_i = 1'b0;
        n = 0;
        while (!update_o && n < 200) begin
            chk("hold_data", 64'(sensors_data_o), 64'(last_pub.data));
            chk("hold_en", 64'(sensors_en_o), 64'(last_pub.en));
            @(negedge clk_i);
            n++;
        end
        chk("drop_update", 64'(update_o), 64'd1);
        repeat (6) @(negedge clk_i);
        chk("drop_busy", 64'(busy_o), 64'd0);
        chk("drop_req", 64'(sensor_req_o), 64'd0);
        chk("drop_one_pulse", 64'(upd_cnt - u0), 64'd1);

        // Stray acks on sensor 3 then reset during sensor 4's REQ
        for (int k = 0; k < N; k++) begin delay[k] = 0; vals[k] = 8'(60 + k); end
        stray[3] = 1'b1;
        u0 = upd_cnt;
        @(negedge clk_i);
        scan_en_i = 1'b1;
        wait_req(4, 200);
        chk("stray_len3", 64'(req_len[3]), 64'(T));
        #2 rst_i = 1'b1;
        #1 chk_zero("async_reset");
        scan_en_i = 1'b0;
        stray[3] = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset_no_pulse", 64'(upd_cnt - u0), 64'd0);
        run_round("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
